// File: rtl/ac97_pkg.sv
// AC-link frame geometry and codec register indices shared by the receive deframer.
// Defining AC97_RX_PCM_EN extends the shift register to hold PCM record slots 3 and 4.
package ac97_pkg;

    localparam int TAG_POS   = 0;
    localparam int SLOT1_POS = 16;
    localparam int SLOT2_POS = 36;
    localparam int SLOT3_POS = 56;
    localparam int SLOT4_POS = 76;
    localparam int FRAME_LEN = 256;
    localparam int SLOT_BITS = 20;
    localparam int SYNC_LEN  = 16;

    localparam logic [6:0] REG_PWR_ADDR  = 7'h26;
    localparam logic [6:0] REG_VID1_ADDR = 7'h7C;
    localparam logic [6:0] REG_VID2_ADDR = 7'h7E;

`ifdef AC97_RX_PCM_EN
    localparam int SHIFT_LEN = SLOT4_POS + SLOT_BITS;
`else
    localparam int SHIFT_LEN = SLOT3_POS;
`endif

    localparam logic [7:0] POS_TAG_DONE    = 8'(SLOT1_POS);
    localparam logic [7:0] POS_STATUS_DONE = 8'(SLOT3_POS);
    localparam logic [7:0] POS_PCM_DONE    = 8'(SLOT4_POS + SLOT_BITS);
    localparam logic [7:0] POS_LAST        = 8'(FRAME_LEN - 1);

    typedef enum logic {
        ALIGN_UNLOCKED,
        ALIGN_LOCKED
    } align_state_t;

    // The shift register is continuous, so at position done_pos frame bit f sits here.
    function automatic int sr_index(input int done_pos, input int frame_bit);
        return done_pos - 1 - frame_bit;
    endfunction

endpackage

// File: rtl/ac97_rx_align.sv
// SYNC rising-edge detection, frame bit position counter and lock / misalignment tracking.
module ac97_rx_align
    import ac97_pkg::*;
(
    input  logic       ac97_bitclk,
    input  logic       rst,
    input  logic       ac97_sync,
    output logic [7:0] pos,
    output logic       locked,
    output logic       frame_err,
    output logic       decode_en
);

    align_state_t state;
    logic         sync_q;
    logic         sync_rise;

    assign sync_rise = ac97_sync & ~sync_q;
    assign locked    = (state == ALIGN_LOCKED);
    // A realigning SYNC edge suppresses any slot processing that lands on the same cycle.
    assign decode_en = locked & ~sync_rise;

    always_ff @(posedge ac97_bitclk) begin
        if (rst) begin
            sync_q    <= 1'b0;
            pos       <= 8'd0;
            state     <= ALIGN_UNLOCKED;
            frame_err <= 1'b0;
        end else begin
            sync_q <= ac97_sync;
            if (sync_rise) begin
                pos   <= POS_LAST;
                state <= ALIGN_LOCKED;
                if (state == ALIGN_LOCKED && pos != POS_LAST - 8'd1) begin
                    frame_err <= 1'b1;
                end
            end else begin
                pos <= pos + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ac97_rx_frame.sv
// AC-link receive deframer: TAG, codec status read-back and register shadows.
// Optional PCM record capture of slots 3/4 is enabled with AC97_RX_PCM_EN.
module ac97_rx_frame
    import ac97_pkg::*;
(
    input  logic        ac97_bitclk,
    input  logic        rst,
    input  logic        ac97_sync,
    input  logic        ac97_sdata_in,
    output logic        locked,
    output logic        codec_ready,
    output logic [11:0] slot_valid,
    output logic        status_valid,
    output logic [6:0]  status_addr,
    output logic [15:0] status_data,
    output logic [15:0] reg_pwr,
    output logic [31:0] reg_vid,
    output logic        pcm_valid,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        frame_err
);

    localparam int TAG_IDX      = sr_index(SLOT1_POS, TAG_POS);
    localparam int ST_SLOT1_MSB = sr_index(SLOT3_POS, SLOT1_POS);
    localparam int ST_SLOT2_MSB = sr_index(SLOT3_POS, SLOT2_POS);

    logic                 sdin_q;
    logic [7:0]           pos;
    logic                 decode_en;
    logic [SHIFT_LEN-1:0] shreg;
    logic [6:0]           status_addr_w;
    logic [15:0]          status_data_w;

    ac97_rx_align u_align (
        .ac97_bitclk (ac97_bitclk),
        .rst         (rst),
        .ac97_sync   (ac97_sync),
        .pos         (pos),
        .locked      (locked),
        .frame_err   (frame_err),
        .decode_en   (decode_en)
    );

    // The codec launches data on the rising edge, so it is captured half a cycle later.
    always_ff @(negedge ac97_bitclk) begin
        if (rst) begin
            sdin_q <= 1'b0;
        end else begin
            sdin_q <= ac97_sdata_in;
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (rst) begin
            shreg <= '0;
        end else begin
            shreg <= {shreg[SHIFT_LEN-2:0], sdin_q};
        end
    end

    assign status_addr_w = shreg[ST_SLOT1_MSB-1 -: 7];
    assign status_data_w = shreg[ST_SLOT2_MSB -: 16];

    always_ff @(posedge ac97_bitclk) begin
        if (rst) begin
            codec_ready  <= 1'b0;
            slot_valid   <= '0;
            status_valid <= 1'b0;
            status_addr  <= '0;
            status_data  <= '0;
            reg_pwr      <= '0;
            reg_vid      <= '0;
        end else begin
            status_valid <= 1'b0;
            if (decode_en && pos == POS_TAG_DONE) begin
                codec_ready <= shreg[TAG_IDX];
                for (int j = 0; j < 12; j++) begin
                    slot_valid[j] <= shreg[TAG_IDX-1-j];
                end
            end
            if (decode_en && pos == POS_STATUS_DONE && codec_ready && slot_valid[0] && slot_valid[1]) begin
                status_valid <= 1'b1;
                status_addr  <= status_addr_w;
                status_data  <= status_data_w;
                case (status_addr_w)
                    REG_PWR_ADDR:  reg_pwr         <= status_data_w;
                    REG_VID1_ADDR: reg_vid[31:16]  <= status_data_w;
                    REG_VID2_ADDR: reg_vid[15:0]   <= status_data_w;
                    default: ;
                endcase
            end
        end
    end

`ifdef AC97_RX_PCM_EN
    localparam int PCM_SLOT3_MSB = sr_index(SLOT4_POS + SLOT_BITS, SLOT3_POS);
    localparam int PCM_SLOT4_MSB = sr_index(SLOT4_POS + SLOT_BITS, SLOT4_POS);

    logic unused_shreg;
    assign unused_shreg = ^shreg[SHIFT_LEN-1:PCM_SLOT3_MSB+1];

    always_ff @(posedge ac97_bitclk) begin
        if (rst) begin
            pcm_valid <= 1'b0;
            pcm_left  <= '0;
            pcm_right <= '0;
        end else begin
            pcm_valid <= 1'b0;
            if (decode_en && pos == POS_PCM_DONE && slot_valid[2] && slot_valid[3]) begin
                pcm_valid <= 1'b1;
                pcm_left  <= shreg[PCM_SLOT3_MSB -: SLOT_BITS];
                pcm_right <= shreg[PCM_SLOT4_MSB -: SLOT_BITS];
            end
        end
    end
`else
    logic unused_shreg;
    assign unused_shreg = ^{shreg[SHIFT_LEN-1:ST_SLOT1_MSB], shreg[ST_SLOT1_MSB-8:ST_SLOT2_MSB+1], shreg[2:0]};

    assign pcm_valid = 1'b0;
    assign pcm_left  = '0;
    assign pcm_right = '0;
`endif

endmodule

// File: doc/ac97_rx_frame.md
# ac97_rx_frame

Receive-side AC-link deframer on the codec-to-controller serial line, running beside the AC'97 link transmitter. It aligns to the link's SYNC output, deserialises each 256-bit input frame, and extracts the TAG, the codec status (register read-back from slots 1/2) and, optionally, the PCM record slots 3/4. Results appear as registered outputs with single-cycle valid pulses for the configuration sequencer and debug logic.

## Interface
Parameters:
- none

Ports:
- ac97_bitclk  in  1  codec bit clock (12.288 MHz); all state on rising edge except the input capture flop
- rst  in  1  reset, synchronous, active-high
- ac97_sync  in  1  SYNC as driven by the link transmitter
- ac97_sdata_in  in  1  codec serial data
- locked  out  1  frame alignment acquired
- codec_ready  out  1  TAG bit 0 of the last complete frame
- slot_valid  out  12  TAG bits 1..12 (slot 1 at bit 0)
- status_valid  out  1  one-cycle pulse: new status_addr/status_data
- status_addr  out  7  slot 1 bits 18:12
- status_data  out  16  slot 2 bits 19:4
- reg_pwr  out  16  shadow of register 0x26
- reg_vid  out  32  shadow of {0x7C, 0x7E}
- pcm_valid  out  1  one-cycle pulse: new pcm_left/pcm_right
- pcm_left  out  20  slot 3
- pcm_right  out  20  slot 4
- frame_err  out  1  sticky SYNC misalignment flag

## Operation
- Input capture: ac97_sdata_in sampled on falling edge of ac97_bitclk into sdin_q; all other logic uses sdin_q on the next rising edge.
- SYNC edge detect: sync_q registered on rising edge; sync_rise = ac97_sync & ~sync_q.
- Position counter pos[7:0]: sync_rise forces pos to 255; otherwise increments mod 256. At the rising edge with pos==k, sdin_q holds frame bit k (bit 0 = TAG MSB).
- States: UNLOCKED (after reset) -> LOCKED on first sync_rise. While UNLOCKED no outputs update.
- sync_rise in LOCKED with pos != 254 (i.e. next value not naturally 255): set frame_err, realign, discard current frame (no pulses this frame).
- Shift register collects bits 0..95 MSB-first per slot.
- pos==16: latch TAG: codec_ready = bit 0, slot_valid = bits 1..12.
- pos==56 (slot 2 complete): if codec_ready & slot_valid[0] & slot_valid[1]: update status_addr/status_data, pulse status_valid; if addr==0x26 update reg_pwr, 0x7C -> reg_vid[31:16], 0x7E -> reg_vid[15:0].
- pos==96: if slot_valid[2] & slot_valid[3]: update pcm_left/pcm_right, pulse pcm_valid (only with AC97_RX_PCM_EN).
- Bits 96..255 ignored.

## Timing
- Reset: all outputs 0, state UNLOCKED, pos 0.
- locked rises one cycle after first sync_rise.
- status_valid: exactly one cycle, at the edge after pos==56 is processed; at most once per frame.
- pcm_valid: exactly one cycle, after pos==96; at most once per frame.
- Status data latency: last slot-2 bit on line -> status_valid = 1.5 bit clocks.
- Reset mid-frame: immediate return to UNLOCKED, partial frame discarded, frame_err cleared.
- sync_rise coinciding with pos==56 or 96 processing: realignment wins, no pulse.
- Outputs hold value between updates.

## Configuration
- AC97_RX_PCM_EN defined: slot 3/4 capture, pcm_valid, pcm_left, pcm_right active; shift register 96 bits.
- Undefined: pcm outputs tied 0, shift register 56 bits, pos==96 logic absent.

## Structure
- Package ac97_pkg: slot bit-position constants (TAG 0, SLOT1 16, SLOT2 36, SLOT3 56, SLOT4 76, FRAME 256), register index constants (0x26, 0x7C, 0x7E), SYNC-length constant 16.
- Sub-module ac97_rx_align: SYNC edge detect, pos counter, lock/frame_err state.

## Test plan
- Bench model codec drives frames aligned to link SYNC, TAG=0xF800, slot1 addr 0x26, slot2 data 0x000F -> status_valid one pulse, status_addr=0x26, status_data=0x000F, reg_pwr=0x000F.
- Successive frames addr 0x7C data 0x4144, then 0x7E data 0x5370 -> reg_vid=0x41445370.
- TAG=0x7800 (codec not ready) with valid slot data -> no status_valid, codec_ready=0, shadows unchanged.
- PCM_EN build, TAG 0x9800, slot3=0x12345, slot4=0xABCDE -> pcm_valid pulse, pcm_left=0x12345, pcm_right=0xABCDE.
- Inject extra SYNC rise at pos 100 -> frame_err=1 sticky, pos realigned, next full frame decodes correctly.
- Assert rst at pos 40 -> all outputs 0, locked=0 until next SYNC; no status_valid for interrupted frame.
